// File: rtl/quad_gate_bist_ctrl.sv
// rtl/quad_gate_bist_ctrl.sv - BIST sequencer for a quad 2-input gate package
//
// Walks gates 0..3, applying {A,B} = 11, 01, 10, 00 to one gate at a time
// while the other gates see 00. After SETTLE_CYCLES wait cycles it compares
// all four Y bits against TRUTH and accumulates a sticky failure mask and
// the first failing {gate, vector}.
//
// Ports:
//   clk        - clock, rising edge
//   clr_n      - asynchronous active-low reset
//   start      - begin a run (ignored while busy)
//   abort      - synchronous abort of a running test
//   y[3:0]     - gate outputs from the chip under test
//   a[3:0]     - gate A inputs to the chip
//   b[3:0]     - gate B inputs to the chip
//   busy       - run in progress
//   done       - last run completed (held until next start or reset)
//   pass       - valid with done; 1 = no mismatch seen
//   fail_mask  - sticky per-Y mismatch flags
//   fail_valid - first_fail holds a captured mismatch
//   first_fail - {gate[1:0], vec[1:0]} of the first mismatching compare

module quad_gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  TRUTH         = 4'b1110
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] y,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic       fail_valid,
    output logic [3:0] first_fail
);

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] g, g_nxt;
    logic [1:0] v, v_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] a_nxt, b_nxt;
    logic       busy_nxt, done_nxt, pass_nxt, fail_valid_nxt;
    logic [3:0] fail_mask_nxt, first_fail_nxt;
    logic [3:0] exp_y, mism;
    logic [3:0] gv_inc;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= S_IDLE;
            g          <= 2'd0;
            v          <= 2'd0;
            cnt        <= 8'd0;
            a          <= 4'd0;
            b          <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 4'd0;
            fail_valid <= 1'b0;
            first_fail <= 4'd0;
        end else begin
            state      <= state_nxt;
            g          <= g_nxt;
            v          <= v_nxt;
            cnt        <= cnt_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            fail_mask  <= fail_mask_nxt;
            fail_valid <= fail_valid_nxt;
            first_fail <= first_fail_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        g_nxt          = g;
        v_nxt          = v;
        cnt_nxt        = cnt;
        a_nxt          = a;
        b_nxt          = b;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;
        fail_mask_nxt  = fail_mask;
        fail_valid_nxt = fail_valid;
        first_fail_nxt = first_fail;
        gv_inc         = {g, v} + 4'd1;

        // Idle gates are driven 00, so indexing TRUTH by each gate's own
        // {A,B} yields TRUTH[00] for them and the vector's entry for gate g.
        // Case-inequality makes X/Z on y a mismatch in simulation.
        for (int i = 0; i < 4; i++) begin
            exp_y[i] = TRUTH[{a[i], b[i]}];
            mism[i]  = (y[i] !== exp_y[i]);
        end

        case (state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_nxt      = S_RUN;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                    fail_mask_nxt  = 4'd0;
                    fail_valid_nxt = 1'b0;
                    first_fail_nxt = 4'd0;
                    g_nxt          = 2'd0;
                    v_nxt          = 2'd0;
                    cnt_nxt        = CNT_LOAD;
                    busy_nxt       = 1'b1;
                    a_nxt          = 4'b0001;
                    b_nxt          = 4'b0001;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    a_nxt     = 4'd0;
                    b_nxt     = 4'd0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    fail_mask_nxt = fail_mask | mism;
                    if (!fail_valid && (mism != 4'd0)) begin
                        fail_valid_nxt = 1'b1;
                        first_fail_nxt = {g, v};
                    end
                    if ((g == 2'd3) && (v == 2'd3)) begin
                        state_nxt = S_FIN;
                        a_nxt     = 4'd0;
                        b_nxt     = 4'd0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (fail_mask_nxt == 4'd0);
                    end else begin
                        g_nxt   = gv_inc[3:2];
                        v_nxt   = gv_inc[1:0];
                        cnt_nxt = CNT_LOAD;
                        // Vector order 11, 01, 10, 00: A = ~v[0], B = ~v[1].
                        a_nxt   = {3'b000, ~gv_inc[0]} << gv_inc[3:2];
                        b_nxt   = {3'b000, ~gv_inc[1]} << gv_inc[3:2];
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                a_nxt     = 4'd0;
                b_nxt     = 4'd0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_quad_gate_bist_ctrl.sv
// tb/tb_quad_gate_bist_ctrl.sv - self-checking bench for quad_gate_bist_ctrl

module tb_quad_gate_bist_ctrl;

    logic       clk = 1'b0;
    logic       clr_n, start, abort;
    logic [3:0] y, a, b, fail_mask, first_fail;
    logic       busy, done, pass, fail_valid;
    logic [3:0] y2, a2, b2, fail_mask2, first_fail2;
    logic       busy2, done2, pass2, fail_valid2;
    int         mode;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    quad_gate_bist_ctrl #(.SETTLE_CYCLES(4), .TRUTH(4'b1110)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .y(y),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .fail_valid(fail_valid), .first_fail(first_fail)
    );

    quad_gate_bist_ctrl #(.SETTLE_CYCLES(0), .TRUTH(4'b0111)) dut_nand (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_mask(fail_mask2), .fail_valid(fail_valid2), .first_fail(first_fail2)
    );

    // Chip models: 0 good OR, 1 Y2 stuck-0, 2 bridge Y1=A1|B1|A0,
    // 3 all Y stuck-1, 4 AND chip, 5 Y0 stuck-1, 6 XOR chip
    always_comb begin
        y = a | b;
        case (mode)
            1: y = (a | b) & 4'b1011;
            2: y[1] = a[1] | b[1] | a[0];
            3: y = 4'b1111;
            4: y = a & b;
            5: y = (a | b) | 4'b0001;
            6: y = a ^ b;
            default: y = a | b;
        endcase
    end

    assign y2 = ~(a2 & b2);

    typedef struct {
        int         mode;
        logic       pass;
        logic [3:0] mask;
        logic       fv;
        logic [3:0] ff;
    } vec_t;

    typedef struct {
        logic       pass;
        logic [3:0] mask;
        logic       fv;
        logic [3:0] ff;
        int         lat;
    } exp_t;

    vec_t tbl[7];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_exp(input logic p, input logic [3:0] m, input logic fv,
                            input logic [3:0] ff, input int lat);
        exp_t e;
        e.pass = p; e.mask = m; e.fv = fv; e.ff = ff; e.lat = lat;
        sb.push_back(e);
    endtask

    // Counts edges after the start edge until done rises; n0 edges already elapsed.
    task automatic wait_done(input bit use2, input bit chk_ab, input int n0, output int n);
        n = n0;
        do begin
            @(posedge clk);
            #1 n++;
            if (chk_ab) begin
                if (n == 1)  begin check("a_v0_g0", a, 4'b0001); check("b_v0_g0", b, 4'b0001); end
                if (n == 5)  begin check("a_v1_g0", a, 4'b0000); check("b_v1_g0", b, 4'b0001); end
                if (n == 20) begin check("a_v0_g1", a, 4'b0010); check("b_v0_g1", b, 4'b0010); end
                if (n == 65) begin check("a_v1_g3", a, 4'b0000); check("b_v1_g3", b, 4'b1000); end
                if (n == 40) check("busy_mid", busy, 1);
            end
        end while (!(use2 ? done2 : done) && n < 300);
        if (!(use2 ? done2 : done)) check("done_timeout", 0, 1);
    endtask

    task automatic score(input bit use2, input int n);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("latency", n, e.lat);
            check("pass", use2 ? pass2 : pass, e.pass);
            check("fail_mask", use2 ? fail_mask2 : fail_mask, e.mask);
            check("fail_valid", use2 ? fail_valid2 : fail_valid, e.fv);
            check("first_fail", use2 ? first_fail2 : first_fail, e.ff);
            check("busy_end", use2 ? busy2 : busy, 0);
            check("a_end", use2 ? a2 : a, 0);
            check("b_end", use2 ? b2 : b, 0);
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{0, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[1] = '{1, 1'b0, 4'b0100, 1'b1, 4'b1000};
        tbl[2] = '{2, 1'b0, 4'b0010, 1'b1, 4'b0000};
        tbl[3] = '{3, 1'b0, 4'b1111, 1'b1, 4'b0000};
        tbl[4] = '{4, 1'b0, 4'b1111, 1'b1, 4'b0001};
        tbl[5] = '{5, 1'b0, 4'b0001, 1'b1, 4'b0011};
        tbl[6] = '{6, 1'b0, 4'b1111, 1'b1, 4'b0000};

        mode = 0; clr_n = 1'b0; start = 1'b0; abort = 1'b0;
        #12;
        check("rst_busy", busy, 0);  check("rst_done", done, 0);
        check("rst_pass", pass, 0);  check("rst_mask", fail_mask, 0);
        check("rst_fv", fail_valid, 0); check("rst_ff", first_fail, 0);
        check("rst_a", a, 0);        check("rst_b", b, 0);
        @(negedge clk) clr_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            mode = tbl[k].mode;
            push_exp(tbl[k].pass, tbl[k].mask, tbl[k].fv, tbl[k].ff, 80);
            pulse_start();
            check("busy_after_start", busy, 1);
            check("done_cleared", done, 0);
            wait_done(1'b0, 1'b1, 0, n);
            score(1'b0, n);
        end

        // Reset mid-run discards the run
        mode = 0;
        pulse_start();
        repeat (30) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0); check("mrst_done", done, 0);
        check("mrst_a", a, 0);       check("mrst_b", b, 0);
        check("mrst_pass", pass, 0); check("mrst_fv", fail_valid, 0);
        @(negedge clk) clr_n = 1'b1;

        // Fresh run with an ignored second start at cycle 10
        push_exp(1'b1, 4'b0000, 1'b0, 4'b0000, 80);
        pulse_start();
        repeat (9) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, 1'b0, 10, n);
        score(1'b0, n);

        // Abort at cycle 20 of a bridge-fault run; fail state retained
        mode = 2;
        pulse_start();
        repeat (19) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0); check("abort_done", done, 0);
        check("abort_a", a, 0);       check("abort_b", b, 0);
        check("abort_fv", fail_valid, 1); check("abort_ff", first_fail, 4'b0000);
        check("abort_mask", fail_mask, 4'b0010);
        repeat (5) @(posedge clk);
        #1 check("abort_stays_idle", busy, 0);

        mode = 0;
        push_exp(1'b1, 4'b0000, 1'b0, 4'b0000, 80);
        pulse_start();
        wait_done(1'b0, 1'b0, 0, n);
        score(1'b0, n);

        // Abort while finished has no effect
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_fin_done", done, 1);
        check("abort_fin_pass", pass, 1);

        // Abort and start together while finished: start wins
        push_exp(1'b1, 4'b0000, 1'b0, 4'b0000, 80);
        @(negedge clk) begin abort = 1'b1; start = 1'b1; end
        @(posedge clk);
        #1 begin abort = 1'b0; start = 1'b0; end
        check("start_wins_busy", busy, 1);
        wait_done(1'b0, 1'b0, 0, n);
        score(1'b0, n);

        // NAND instance, zero settle
        push_exp(1'b1, 4'b0000, 1'b0, 4'b0000, 16);
        pulse_start();
        check("nand_busy", busy2, 1);
        wait_done(1'b1, 1'b0, 0, n);
        score(1'b1, n);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
